// File: rtl/afe_tot_lfsr_array.sv
// Multi-channel AFE time-over-threshold measurement: per-channel LFSR counters run during an
// injection window, results are snapshotted and read out through a CLK-synchronous SPI slave.
module afe_tot_lfsr_array #(
   parameter int               N_CH  = 4,
   parameter int               CNT_W = 8,
   parameter logic [CNT_W-1:0] TAPS  = CNT_W'(8'h1D),
   parameter logic [CNT_W-1:0] SEED  = {CNT_W{1'b1}},
   parameter int               CFG_W = 8
) (
   input  logic             CLK,
   input  logic             RST_B,
   input  logic             INJ_IN,
   input  logic [N_CH-1:0]  COMP,
   input  logic             SCLK,
   input  logic             CS_B,
   input  logic             MOSI,
   output logic             MISO,
   output logic             INJ_OUT,
   output logic [N_CH-1:0]  HIT,
   output logic [CFG_W-1:0] GPIO,
   output logic             DATA_VALID
);

   localparam int L    = N_CH * (CNT_W + 1);
   localparam int BC_W = $clog2(L + 1);
   // Step count at which the next step is the final one before freezing.
   localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'((32'd1 << CNT_W) - 32'd3);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ARMED = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   function automatic logic [CNT_W-1:0] lfsr_next(input logic [CNT_W-1:0] v);
      return {v[CNT_W-2:0], ^(v & TAPS)};
   endfunction

   logic             inj_s1_r, inj_s2_r, inj_d_r;
   logic [N_CH-1:0]  comp_s1_r, comp_s2_r;
   logic             sclk_s1_r, sclk_s2_r, sclk_d_r;
   logic             cs_s1_r, cs_s2_r, cs_d_r;
   logic             mosi_s1_r, mosi_s2_r;

   logic             inj_rise_s, inj_fall_s, sclk_rise_s, cs_fall_s, cs_rise_s;
   logic [1:0]       state_r, state_nxt_s;
   logic             arm_entry_s, done_s;

   logic [CNT_W-1:0] cnt_r  [N_CH];
   logic [CNT_W-1:0] step_r [N_CH];
   logic [N_CH-1:0]  ovf_r;
   logic [N_CH-1:0]  hit_r;
   logic [L-1:0]     snap_s, shadow_r;

   logic [L-1:0]     sr_r, sr_nxt_s;
   logic [BC_W-1:0]  bitcnt_r, bc_nxt_s;
   logic [CFG_W-1:0] gpio_r;
   logic             dv_r, new_snap_r, miso_r;

   // Two-flop synchronisers plus one delay stage for edge detection; idle-high lines reset high.
   always_ff @(posedge CLK or negedge RST_B) begin
      if (!RST_B) begin
         inj_s1_r  <= 1'b1;
         inj_s2_r  <= 1'b1;
         inj_d_r   <= 1'b1;
         comp_s1_r <= '0;
         comp_s2_r <= '0;
         sclk_s1_r <= 1'b0;
         sclk_s2_r <= 1'b0;
         sclk_d_r  <= 1'b0;
         cs_s1_r   <= 1'b1;
         cs_s2_r   <= 1'b1;
         cs_d_r    <= 1'b1;
         mosi_s1_r <= 1'b0;
         mosi_s2_r <= 1'b0;
      end else begin
         inj_s1_r  <= INJ_IN;
         inj_s2_r  <= inj_s1_r;
         inj_d_r   <= inj_s2_r;
         comp_s1_r <= COMP;
         comp_s2_r <= comp_s1_r;
         sclk_s1_r <= SCLK;
         sclk_s2_r <= sclk_s1_r;
         sclk_d_r  <= sclk_s2_r;
         cs_s1_r   <= CS_B;
         cs_s2_r   <= cs_s1_r;
         cs_d_r    <= cs_s2_r;
         mosi_s1_r <= MOSI;
         mosi_s2_r <= mosi_s1_r;
      end
   end

   assign inj_rise_s  = inj_s2_r & ~inj_d_r;
   assign inj_fall_s  = ~inj_s2_r & inj_d_r;
   assign sclk_rise_s = sclk_s2_r & ~sclk_d_r;
   assign cs_fall_s   = ~cs_s2_r & cs_d_r;
   assign cs_rise_s   = cs_s2_r & ~cs_d_r;

   assign arm_entry_s = (state_r == ST_IDLE) && inj_rise_s;
   assign done_s      = (state_r == ST_DONE);

   // Measurement FSM next state.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (inj_rise_s) state_nxt_s = ST_ARMED;
            else            state_nxt_s = ST_IDLE;
         end
         ST_ARMED: begin
            if (inj_fall_s) state_nxt_s = ST_DONE;
            else            state_nxt_s = ST_ARMED;
         end
         ST_DONE: state_nxt_s = ST_IDLE;
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Measurement FSM state register.
   always_ff @(posedge CLK or negedge RST_B) begin
      if (!RST_B) state_r <= ST_IDLE;
      else        state_r <= state_nxt_s;
   end

   // Per-channel LFSR counters; the shadow step count freezes a channel before it can wrap to SEED.
   always_ff @(posedge CLK or negedge RST_B) begin
      if (!RST_B) begin
         for (int i = 0; i < N_CH; i++) begin
            cnt_r[i]  <= SEED;
            step_r[i] <= '0;
         end
         ovf_r <= '0;
         hit_r <= '0;
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            if (arm_entry_s) begin
               cnt_r[i]  <= SEED;
               step_r[i] <= '0;
               ovf_r[i]  <= 1'b0;
               hit_r[i]  <= 1'b0;
            end else if ((state_r == ST_ARMED) && comp_s2_r[i]) begin
               hit_r[i] <= 1'b1;
               if (!ovf_r[i]) begin
                  cnt_r[i]  <= lfsr_next(cnt_r[i]);
                  step_r[i] <= step_r[i] + CNT_W'(1'b1);
                  if (step_r[i] == STEP_LAST) ovf_r[i] <= 1'b1;
               end
            end
         end
      end
   end

   // Snapshot word: OVF flags on top, then channel counters from highest to lowest.
   always_comb begin
      snap_s = '0;
      for (int i = 0; i < N_CH; i++) begin
         snap_s[i*CNT_W +: CNT_W] = cnt_r[i];
      end
      snap_s[N_CH*CNT_W +: N_CH] = ovf_r;
   end

   // Shadow register captures the snapshot in DONE.
   always_ff @(posedge CLK or negedge RST_B) begin
      if (!RST_B)      shadow_r <= '0;
      else if (done_s) shadow_r <= snap_s;
      else             shadow_r <= shadow_r;
   end

   // SPI shift register and bit counter next values.
   always_comb begin
      sr_nxt_s = sr_r;
      bc_nxt_s = bitcnt_r;
      if (cs_fall_s) begin
         sr_nxt_s = shadow_r;
         bc_nxt_s = '0;
      end else if (sclk_rise_s && !cs_s2_r) begin
         sr_nxt_s = {sr_r[L-2:0], mosi_s2_r};
         if (bitcnt_r != BC_W'(L)) bc_nxt_s = bitcnt_r + BC_W'(1'b1);
         else                      bc_nxt_s = bitcnt_r;
      end else begin
         sr_nxt_s = sr_r;
         bc_nxt_s = bitcnt_r;
      end
   end

   // SPI state, GPIO and DATA_VALID; a snapshot taken during an open frame stays unread.
   always_ff @(posedge CLK or negedge RST_B) begin
      if (!RST_B) begin
         sr_r       <= '0;
         bitcnt_r   <= '0;
         gpio_r     <= '0;
         dv_r       <= 1'b0;
         new_snap_r <= 1'b0;
         miso_r     <= 1'b0;
      end else begin
         sr_r     <= sr_nxt_s;
         bitcnt_r <= bc_nxt_s;
         miso_r   <= ~cs_s1_r & sr_nxt_s[L-1];
         if (cs_rise_s) gpio_r <= sr_r[CFG_W-1:0];
         if (done_s) begin
            dv_r       <= 1'b1;
            new_snap_r <= 1'b1;
         end else begin
            if (cs_rise_s && (bitcnt_r == BC_W'(L)) && !new_snap_r) dv_r <= 1'b0;
            if (cs_fall_s) new_snap_r <= 1'b0;
         end
      end
   end

   assign INJ_OUT    = INJ_IN;
   assign HIT        = hit_r;
   assign GPIO       = gpio_r;
   assign DATA_VALID = dv_r;
   assign MISO       = miso_r;

endmodule

// File: tb/tb_afe_tot_lfsr_array.sv
// Self-checking bench for afe_tot_lfsr_array: vector table of windows/frames, a MISO bit
// scoreboard, and hand-written overlap and reset sequences.
module tb_afe_tot_lfsr_array;

   localparam int N_CH = 4;
   localparam int CNT_W = 8;
   localparam int L = N_CH * (CNT_W + 1);

   logic             CLK = 1'b0;
   logic             RST_B = 1'b0;
   logic             INJ_IN = 1'b0;
   logic [N_CH-1:0]  COMP = '0;
   logic             SCLK = 1'b0;
   logic             CS_B = 1'b1;
   logic             MOSI = 1'b0;
   logic             MISO;
   logic             INJ_OUT;
   logic [N_CH-1:0]  HIT;
   logic [7:0]       GPIO;
   logic             DATA_VALID;

   afe_tot_lfsr_array dut (
      .CLK(CLK), .RST_B(RST_B), .INJ_IN(INJ_IN), .COMP(COMP), .SCLK(SCLK), .CS_B(CS_B),
      .MOSI(MOSI), .MISO(MISO), .INJ_OUT(INJ_OUT), .HIT(HIT), .GPIO(GPIO),
      .DATA_VALID(DATA_VALID)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [3:0][8:0] plen;
      int              fbits;
      logic [7:0]      tail;
      logic [3:0]      exp_hit;
      logic            exp_dv;
   } vec_t;

   vec_t vt [5];
   int   n_vec = 0;
   int   n_err = 0;
   logic exp_q [$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   // Independent reference: x^8 style shift-left with feedback from bits 0,2,3,4, frozen after 254 steps.
   function automatic logic [7:0] lfsr_model(input int n);
      logic [7:0] v;
      v = 8'hFF;
      for (int k = 0; k < n && k < 254; k++) v = {v[6:0], v[0] ^ v[2] ^ v[3] ^ v[4]};
      return v;
   endfunction

   function automatic logic [L-1:0] snap_model(input logic [3:0][8:0] plen);
      logic [L-1:0] s;
      s = '0;
      for (int c = 0; c < N_CH; c++) begin
         s[c*8 +: 8] = lfsr_model(int'(plen[c]));
         s[32 + c]   = (plen[c] >= 9'd254);
      end
      return s;
   endfunction

   task automatic set_vec(input int idx, input logic [8:0] p3, input logic [8:0] p2,
                          input logic [8:0] p1, input logic [8:0] p0, input int fbits,
                          input logic [7:0] tail, input logic [3:0] hit, input logic dv);
      vt[idx].plen    = {p3, p2, p1, p0};
      vt[idx].fbits   = fbits;
      vt[idx].tail    = tail;
      vt[idx].exp_hit = hit;
      vt[idx].exp_dv  = dv;
   endtask

   task automatic run_window(input logic [3:0][8:0] plen);
      int mx;
      mx = 0;
      for (int c = 0; c < N_CH; c++) if (int'(plen[c]) > mx) mx = int'(plen[c]);
      INJ_IN = 1'b1;
      tick(8);
      chk("inj_out", {63'd0, INJ_OUT}, 64'd1);
      for (int t = 0; t < mx; t++) begin
         for (int c = 0; c < N_CH; c++) COMP[c] = (t < int'(plen[c]));
         tick(1);
      end
      COMP = '0;
      tick(6);
      INJ_IN = 1'b0;
      tick(8);
   endtask

   task automatic open_frame(input logic [L-1:0] snap, input int nbits);
      CS_B = 1'b0;
      for (int i = 0; i < nbits; i++) exp_q.push_back(snap[L-1-i]);
      tick(6);
   endtask

   task automatic spi_shift(input int first, input int cnt, input int total, input logic [L-1:0] mv);
      for (int i = first; i < first + cnt; i++) begin
         MOSI = mv[total-1-i];
         tick(4);
         if (exp_q.size() > 0) begin
            chk($sformatf("miso_bit%0d", i), {63'd0, MISO}, {63'd0, exp_q.pop_front()});
         end else begin
            n_vec++;
            n_err++;
            $display("FAIL miso_scoreboard: bit %0d has no expected value", i);
         end
         SCLK = 1'b1;
         tick(4);
         SCLK = 1'b0;
      end
   endtask

   task automatic close_frame(input logic [7:0] exp_gpio, input logic exp_dv);
      tick(4);
      CS_B = 1'b1;
      tick(6);
      chk("gpio", {56'd0, GPIO}, {56'd0, exp_gpio});
      chk("dv_after_frame", {63'd0, DATA_VALID}, {63'd0, exp_dv});
      chk("miso_idle", {63'd0, MISO}, 64'd0);
      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      logic [L-1:0] snap_a, snap_b, mv;
      logic [3:0][8:0] pa, pb;

      set_vec(0, 9'd0,  9'd0,   9'd0,  9'd2,   36, 8'hA5, 4'b0001, 1'b0);
      set_vec(1, 9'd0,  9'd300, 9'd0,  9'd0,   36, 8'h5A, 4'b0100, 1'b0);
      set_vec(2, 9'd40, 9'd1,   9'd17, 9'd5,   8,  8'h3C, 4'b1111, 1'b1);
      set_vec(3, 9'd3,  9'd0,   9'd254, 9'd253, 36, 8'hC3, 4'b1011, 1'b0);
      set_vec(4, 9'd0,  9'd0,   9'd0,  9'd0,   20, 8'h96, 4'b0000, 1'b1);

      // Reset with active inputs, then release with the window already high.
      INJ_IN = 1'b1;
      COMP   = 4'hF;
      tick(5);
      chk("rst_hit", {60'd0, HIT}, 64'd0);
      chk("rst_gpio", {56'd0, GPIO}, 64'd0);
      chk("rst_dv", {63'd0, DATA_VALID}, 64'd0);
      chk("rst_miso", {63'd0, MISO}, 64'd0);
      RST_B = 1'b1;
      tick(20);
      chk("post_rst_hit", {60'd0, HIT}, 64'd0);
      chk("post_rst_dv", {63'd0, DATA_VALID}, 64'd0);
      INJ_IN = 1'b0;
      COMP   = '0;
      tick(10);

      for (int v = 0; v < 5; v++) begin
         run_window(vt[v].plen);
         chk($sformatf("v%0d_hit", v), {60'd0, HIT}, {60'd0, vt[v].exp_hit});
         chk($sformatf("v%0d_dv", v), {63'd0, DATA_VALID}, 64'd1);
         mv = {28'h3C71E5A, vt[v].tail};
         open_frame(snap_model(vt[v].plen), vt[v].fbits);
         spi_shift(0, vt[v].fbits, vt[v].fbits, mv);
         close_frame(vt[v].tail, vt[v].exp_dv);
      end

      // Overlap: new snapshot lands while a frame is half shifted.
      pa = {9'd0, 9'd0, 9'd0, 9'd4};
      pb = {9'd6, 9'd0, 9'd0, 9'd0};
      snap_a = snap_model(pa);
      snap_b = snap_model(pb);
      run_window(pa);
      mv = {28'h1234567, 8'h69};
      open_frame(snap_a, L);
      spi_shift(0, 10, L, mv);
      run_window(pb);
      chk("ovl_hit", {60'd0, HIT}, 64'h8);
      spi_shift(10, L - 10, L, mv);
      close_frame(8'h69, 1'b1);
      mv = {28'h0FEDCBA, 8'h17};
      open_frame(snap_b, L);
      spi_shift(0, L, L, mv);
      close_frame(8'h17, 1'b0);

      // Reset in the middle of a measurement.
      run_window({9'd0, 9'd0, 9'd1, 9'd0});
      chk("pre_abort_dv", {63'd0, DATA_VALID}, 64'd1);
      INJ_IN = 1'b1;
      tick(8);
      COMP = 4'hF;
      tick(5);
      chk("mid_hit", {60'd0, HIT}, 64'hF);
      RST_B = 1'b0;
      #1;
      chk("abort_hit", {60'd0, HIT}, 64'd0);
      chk("abort_dv", {63'd0, DATA_VALID}, 64'd0);
      chk("abort_gpio", {56'd0, GPIO}, 64'd0);
      tick(3);
      RST_B = 1'b1;
      tick(10);
      chk("abort_rel_hit", {60'd0, HIT}, 64'd0);
      INJ_IN = 1'b0;
      COMP   = '0;
      tick(5);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
